inst_queue: RTL and testbench
=============================

INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 16, meaning: number of fetch-packet entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter PW, default ID_WIDTH (from cpu_params), meaning: instruction slots per packet.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  backend redirect; discards all queued packets.
REQ-006 in_valid  input  1  fetch presents a packet.
REQ-007 in_ready  output  1  queue accepts a packet this cycle.
REQ-008 in_packet  input  fetch_packet_t  pc[31:0]; valid[PW]; inst[PW][31:0]; predict_taken[PW]; predict_target[PW][31:0].
REQ-009 to_id  fifo_backend_itf.fifo  modport; valid (output, 1), ready (input, 1), packet (output, fetch_packet_t) to the decode/rename stage.
REQ-010 occupancy  output  $clog2(DEPTH)+1  entries currently held; debug/perf only.

Function
REQ-011 Storage: DEPTH-entry circular buffer; read/write pointers $clog2(DEPTH)+1 bits wide; MSB is the wrap bit.
REQ-012 Empty when pointers are fully equal; full when index bits are equal and wrap bits differ.
REQ-013 in_ready SHALL be !full, registered-state-derived only, with no combinational dependence on to_id.ready.
REQ-014 Push occurs when in_valid && in_ready && !flush; the packet is written at wptr and wptr increments by 1 modulo 2*DEPTH.
REQ-015 to_id.valid SHALL be !empty; to_id.packet SHALL be the entry at rptr, driven from storage (no bypass).
REQ-016 Latency: a packet pushed in cycle N SHALL be visible at to_id in cycle N+1 at the earliest.
REQ-017 Pop occurs when to_id.valid && to_id.ready && !flush; rptr increments by 1 modulo 2*DEPTH.
REQ-018 While to_id.valid=1 and to_id.ready=0, to_id.packet SHALL remain stable.
REQ-019 Simultaneous push and pop, queue neither empty nor full: both occur; occupancy unchanged.
REQ-020 Full queue: no push that cycle even if a pop occurs; in_ready rises the following cycle.
REQ-021 Empty queue with push: no pop that cycle (to_id.valid=0); occupancy becomes 1.
REQ-022 Flush dominates: in the cycle flush=1, no push or pop is performed; at the next edge both pointers reset to 0, so the queue is empty in cycle N+1.
REQ-023 Flush while full: in_ready=0 during the flush cycle; in_ready=1 in the next cycle.
REQ-024 occupancy SHALL equal wptr - rptr, computed with width $clog2(DEPTH)+1, range 0..DEPTH.
REQ-025 Packet contents, including per-slot valid bits, SHALL be stored and returned unmodified; entries with all slot valid bits clear are still queued.
REQ-026 Storage array contents need not be reset; only pointers are reset.

Reset
REQ-027 With rst=1 at an edge, wptr=rptr=0 afterwards.
REQ-028 After reset: to_id.valid=0, in_ready=1, occupancy=0.
REQ-029 rst dominates flush, push and pop in the same cycle.
REQ-030 Reset mid-operation discards all queued packets; no stale packet SHALL appear at to_id after reset.

Verification
REQ-031 Reset, then push pc=0x1000, 0x1010, 0x1020 with to_id.ready=0 -> occupancy=3; to_id.packet.pc=0x1000 held stable; then ready=1 for three cycles -> pcs popped in order 0x1000, 0x1010, 0x1020; then to_id.valid=0.
REQ-032 Push DEPTH=16 packets with ready=0 -> in_ready=0 and occupancy=16; a 17th in_valid is not accepted; one pop -> in_ready=1 next cycle.
REQ-033 Continuous in_valid=1 and ready=1 with occupancy=4 for 40 cycles -> occupancy stays 4; pointers wrap twice; output pc sequence contiguous, none lost or duplicated.
REQ-034 Occupancy=7 with flush=1 and in_valid=1 in the same cycle -> next cycle occupancy=0 and to_id.valid=0; the flushed-cycle packet never appears at the output.
REQ-035 Empty queue, push in cycle N -> to_id.valid=0 in N and 1 in N+1 with matching packet; rst=1 asserted with occupancy=5 -> occupancy=0 next cycle.
REQ-036 Random in_valid/ready/flush over 10k cycles against a scoreboard queue -> order and content match, no overflow or underflow.

Source files
------------

// File: rtl/inst_queue_if.sv
// Fetch-to-decode packet channel. Carries one fetch packet per handshake.
// Modport fifo (alias master) is the producing side. Modport slave is the consuming side.
interface inst_queue_if #(
   parameter int unsigned PW = 4  // instruction slots per packet (core ID_WIDTH)
);

   typedef struct packed {
      logic [31:0]          pc;
      logic [PW-1:0]        valid;
      logic [PW-1:0][31:0]  inst;
      logic [PW-1:0]        predict_taken;
      logic [PW-1:0][31:0]  predict_target;
   } fetch_packet_t;

   logic          valid;
   logic          ready;
   fetch_packet_t packet;

   modport fifo   (output valid, output packet, input ready);
   modport master (output valid, output packet, input ready);
   modport slave  (input valid, input packet, output ready);

endinterface

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode/rename.
// This is a circular buffer of whole fetch packets. Each pointer has an extra wrap bit.
// The output is driven straight from storage and has no bypass path, so a pushed packet
// is visible one cycle later at the earliest.
// in_packet uses the same layout as inst_queue_if.fetch_packet_t, flattened MSB-first:
// pc, valid, inst, predict_taken, predict_target.
// DEPTH must be a power of two and at least 2.
module inst_queue #(
   parameter int unsigned  DEPTH = 16,
   parameter int unsigned  PW    = 4,
   localparam int unsigned PktW  = 32 + PW + 32 * PW + PW + 32 * PW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [PktW-1:0]         in_packet,
   inst_queue_if.fifo              to_id,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int unsigned AW     = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = 1;

   logic [AW:0]     wptr_q, wptr_d;
   logic [AW:0]     rptr_q, rptr_d;
   logic [PktW-1:0] mem_q [DEPTH];

   logic full, empty, push, pop;

   // Status flags use registered pointers only, so in_ready never depends on to_id.ready.
   always_comb begin
      empty = (wptr_q == rptr_q);
      full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
      push  = in_valid && !full && !flush;
      pop   = !empty && to_id.ready && !flush;
   end

   // Pointer next-state: flush zeroes both pointers, otherwise each advances on its handshake.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PtrOne;
         if (pop)  rptr_d = rptr_q + PtrOne;
      end
   end

   // Pointer registers. rst overrides flush, push and pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Packet storage has no reset. The pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= in_packet;
   end

   // Outputs come from registered state only.
   always_comb begin
      in_ready      = !full;
      to_id.valid   = !empty;
      to_id.packet  = mem_q[rptr_q[AW-1:0]];
      occupancy     = wptr_q - rptr_q;
   end

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue.
// Directed stimulus runs first, then a random phase.
// A posedge model keeps the expected queue contents.
// A negedge monitor checks the DUT outputs against that model and pops on each handshake.
module tb_inst_queue;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned PW    = 4;
   localparam int unsigned PKW   = 32 + PW + 32 * PW + PW + 32 * PW;

   typedef struct packed {
      logic [31:0]          pc;
      logic [PW-1:0]        valid;
      logic [PW-1:0][31:0]  inst;
      logic [PW-1:0]        predict_taken;
      logic [PW-1:0][31:0]  predict_target;
   } pkt_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           flush = 1'b0;
   logic           in_valid = 1'b0;
   logic           ready = 1'b0;
   logic [PKW-1:0] in_pkt = '0;
   logic           in_ready;
   logic [4:0]     occupancy;

   inst_queue_if #(.PW(PW)) to_id ();
   assign to_id.ready = ready;

   inst_queue #(.DEPTH(DEPTH), .PW(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_packet (in_pkt),
      .to_id     (to_id),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   logic [PKW-1:0] exp_q [$];
   bit             popped = 1'b0;
   bit             mon_en = 1'b0;
   int             checks = 0;
   int             passes = 0;
   int             pre_sz;
   logic [PKW-1:0] mon_got;
   pkt_t           mon_got_s;
   pkt_t           mon_exp_s;
   logic [31:0]    pc;

   // Packet contents are derived from the pc. When pc[7:4]==0, all slot valid bits are clear.
   function automatic logic [PKW-1:0] mk_pkt(input logic [31:0] p_pc);
      pkt_t p;
      p.pc    = p_pc;
      p.valid = p_pc[7:4];
      for (int s = 0; s < PW; s++) begin
         p.inst[s]           = p_pc ^ (32'hA5A5_0000 + 32'(s));
         p.predict_taken[s]  = p_pc[4+s] ^ p_pc[8];
         p.predict_target[s] = p_pc + 32'h100 * 32'(s + 1);
      end
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pc(input logic [31:0] p_pc);
      in_valid = 1'b1;
      in_pkt   = mk_pkt(p_pc);
      step();
   endtask

   // Model: update the expected contents at each edge from the driven inputs.
   always @(posedge clk) begin
      pre_sz = exp_q.size() + (popped ? 1 : 0);
      popped = 1'b0;
      if (rst || flush) exp_q.delete();
      else if (in_valid && pre_sz < DEPTH) exp_q.push_back(in_pkt);
   end

   // Monitor: compare the flags and the head packet, then pop on a handshake.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_valid", 64'(to_id.valid), 64'(exp_q.size() != 0));
         chk("mon_in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
         chk("mon_occupancy", 64'(occupancy), 64'(exp_q.size()));
         if (exp_q.size() != 0) begin
            mon_got   = to_id.packet;
            mon_got_s = mon_got;
            mon_exp_s = exp_q[0];
            checks++;
            if (mon_got === exp_q[0]) passes++;
            else $display("FAIL mon_packet: got pc %h valid %h expected pc %h valid %h",
                          mon_got_s.pc, mon_got_s.valid, mon_exp_s.pc, mon_exp_s.valid);
            if (ready && !flush && !rst) begin
               void'(exp_q.pop_front());
               popped = 1'b1;
            end
         end
      end
   end

   initial begin
      step();
      mon_en = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_valid", 64'(to_id.valid), 64'd0);

      // Push three packets while stalled, then drain them in order.
      ready = 1'b0;
      push_pc(32'h1000);
      push_pc(32'h1010);
      push_pc(32'h1020);
      in_valid = 1'b0;
      chk("occ3", 64'(occupancy), 64'd3);
      chk("hold_pc", 64'(to_id.packet.pc), 64'h1000);
      step();
      chk("hold_pc2", 64'(to_id.packet.pc), 64'h1000);
      ready = 1'b1;
      repeat (3) step();
      chk("drained_valid", 64'(to_id.valid), 64'd0);

      // A packet pushed in cycle N shows up in cycle N+1, not in N.
      in_valid = 1'b1;
      in_pkt   = mk_pkt(32'h2000);
      #1;
      chk("lat_n_valid", 64'(to_id.valid), 64'd0);
      step();
      in_valid = 1'b0;
      chk("lat_n1_valid", 64'(to_id.valid), 64'd1);
      chk("lat_n1_pc", 64'(to_id.packet.pc), 64'h2000);
      step();
      chk("lat_empty", 64'(to_id.valid), 64'd0);

      // Fill to full. A push offered in the same cycle as a pop is refused.
      ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) push_pc(32'h3000 + 32'(i * 16));
      in_valid = 1'b0;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_occ", 64'(occupancy), 64'd16);
      in_valid = 1'b1;
      in_pkt   = mk_pkt(32'h3F00);
      ready    = 1'b1;
      step();
      in_valid = 1'b0;
      chk("after_pop_in_ready", 64'(in_ready), 64'd1);
      chk("after_pop_occ", 64'(occupancy), 64'd15);
      repeat (15) step();
      chk("full_drained", 64'(to_id.valid), 64'd0);

      // Steady streaming at occupancy 4. The pointers wrap during this phase.
      ready = 1'b0;
      for (int i = 0; i < 4; i++) push_pc(32'h4000 + 32'(i * 16));
      ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_pkt = mk_pkt(32'h4040 + 32'(i * 16));
         step();
         chk("steady_occ", 64'(occupancy), 64'd4);
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("steady_drained", 64'(to_id.valid), 64'd0);

      // Flush with occupancy 7 and a push offered. Nothing survives.
      ready = 1'b0;
      for (int i = 0; i < 7; i++) push_pc(32'h5000 + 32'(i * 16));
      chk("occ7", 64'(occupancy), 64'd7);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_pkt   = mk_pkt(32'h5BA0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_occ", 64'(occupancy), 64'd0);
      chk("flush_valid", 64'(to_id.valid), 64'd0);
      ready = 1'b1;
      step();
      chk("flush_no_ghost", 64'(to_id.valid), 64'd0);

      // Flush while full: in_ready stays low in the flush cycle and rises the cycle after.
      ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) push_pc(32'h6000 + 32'(i * 16));
      in_valid = 1'b0;
      flush    = 1'b1;
      chk("flush_full_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0;
      chk("post_flush_in_ready", 64'(in_ready), 64'd1);
      chk("post_flush_occ", 64'(occupancy), 64'd0);

      // Reset at occupancy 5 wins over a push, pop and flush in the same cycle.
      for (int i = 0; i < 5; i++) push_pc(32'h7000 + 32'(i * 16));
      chk("occ5", 64'(occupancy), 64'd5);
      rst      = 1'b1;
      flush    = 1'b1;
      in_valid = 1'b1;
      in_pkt   = mk_pkt(32'h7BB0);
      ready    = 1'b1;
      step();
      rst      = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("rst_mid_occ", 64'(occupancy), 64'd0);
      chk("rst_mid_valid", 64'(to_id.valid), 64'd0);
      step();
      chk("rst_no_stale", 64'(to_id.valid), 64'd0);

      // Random traffic. The monitor checks order and contents on every cycle.
      pc = 32'h8000_0000;
      repeat (10000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         ready    = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 63) == 0);
         in_pkt   = mk_pkt(pc);
         pc       = pc + 32'h10;
         step();
      end
      flush    = 1'b0;
      in_valid = 1'b0;
      ready    = 1'b1;
      repeat (DEPTH + 1) step();
      chk("final_empty", 64'(to_id.valid), 64'd0);
      chk("final_occ", 64'(occupancy), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
